lcd_init_seq: RTL and testbench
===============================

# lcd_init_seq

Power-on initialization sequencer for the HD44780-compatible character LCD, sitting directly upstream of the message-display FSM. After reset it waits for the panel's power-up time and then issues the fixed 8-bit-mode command sequence, with correct enable strobes and per-command settle times. It then raises `init_done`, which hands the LCD bus to the display FSM through the top-level pin mux and enables that FSM. All timing is in clock cycles at 50 MHz.

## Interface
Parameters:
- `POWERON_CYCLES`, 2_000_000: power-up wait before the first command (40 ms).
- `EN_PULSE`, 20: cycles `lcd_en` is held high per command.
- `WAIT_SHORT`, 2500: settle after an ordinary command (50 µs).
- `WAIT_LONG`, 205_000: settle after the first function set (4.1 ms).
- `WAIT_CLEAR`, 100_000: settle after clear display (2 ms).

Ports:
- `clk`  in  1  system clock, 50 MHz; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `reinit`  in  1  single-cycle request to rerun the full sequence.
- `lcd_rs`  out  1  register select; always 0 (command).
- `lcd_rw`  out  1  read/write; always 0 (write).
- `lcd_en`  out  1  enable strobe.
- `lcd_data`  out  8  command byte.
- `init_done`  out  1  high when the sequence is complete; sticky.

## Operation
- Command table, index 0..7, as byte / settle time:
  - 0: 0x38 / LONG
  - 1: 0x38 / SHORT
  - 2: 0x38 / SHORT
  - 3: 0x38 / SHORT
  - 4: 0x08 / SHORT
  - 5: 0x01 / CLEAR
  - 6: 0x06 / SHORT
  - 7: 0x0C / SHORT
- States and transitions:
  - S_POWER_WAIT: count `POWERON_CYCLES`, then go to S_SETUP with index = 0.
  - S_SETUP: drive `lcd_data` = table[index]; 1 cycle; go to S_PULSE.
  - S_PULSE: `lcd_en` = 1 for exactly `EN_PULSE` cycles; go to S_WAIT.
  - S_WAIT: `lcd_en` = 0; count the settle time for table[index]. Then, if index == 7, go to S_DONE; otherwise increment index and go to S_SETUP.
  - S_DONE: `init_done` = 1 and `lcd_en` = 0; `lcd_data` holds 0x0C.
- `reinit` is acted on only in S_DONE. On the next edge `init_done` = 0, state = S_POWER_WAIT and index = 0, and the full sequence repeats with identical timing.
- `reinit` in any other state is ignored; it is not queued.
- `rst` takes priority over everything, including a simultaneous `reinit`.
- `rst` mid-sequence: on the next edge all outputs return to their reset values and the sequence restarts from S_POWER_WAIT.
- `lcd_data` is stable from S_SETUP through the end of S_WAIT, so there is no change while `lcd_en` is high.
- The delay counter is 18 bits minimum, sized for the largest parameter. It is cleared on every state entry and never wraps within a state.

## Timing
- Reset values: `lcd_rs` = 0, `lcd_rw` = 0, `lcd_en` = 0, `lcd_data` = 0x00, `init_done` = 0. Internal state = S_POWER_WAIT, counter = 0, index = 0.
- Cycle 0 is the first rising edge with `rst` = 0.
- Command k occupies 1 + `EN_PULSE` + wait_k cycles.
- `lcd_en` first goes high at cycle `POWERON_CYCLES` + 1.
- `init_done` is first high at cycle T:
  - T = `POWERON_CYCLES` + 8·(1 + `EN_PULSE`) + `WAIT_LONG` + 6·`WAIT_SHORT` + `WAIT_CLEAR`.
  - With default parameters, T = 2_000_000 + 168 + 205_000 + 15_000 + 100_000 = 2_320_168 (≈46.4 ms).
- `reinit` sampled in S_DONE at cycle R: `init_done` = 0 at R + 1, and is high again at R + 1 + T.
- Exactly 8 `lcd_en` pulses per sequence, each exactly `EN_PULSE` cycles wide.

## Structure
- Shared package `lcd_pkg` holds:
  - LCD command byte constants: `LCD_FUNC_8BIT_2L` = 0x38, `LCD_DISP_OFF` = 0x08, `LCD_CLEAR` = 0x01, `LCD_ENTRY_INC` = 0x06, `LCD_DISP_ON` = 0x0C, `LCD_LINE2` = 0xC0. The display FSM uses the same constants.
  - The state enum.
  - The wait-class enum (SHORT / LONG / CLEAR).
- Sub-module `lcd_strobe`: the generic setup / pulse / settle engine. Its inputs are `start`, byte, rs and wait cycles; it outputs `busy` and a `done` pulse. The sequencer owns only the table, index and power wait. The display FSM is later refactored onto the same sub-module.

## Test plan
Benches use small parameters: `POWERON_CYCLES` = 10, `EN_PULSE` = 2, `WAIT_SHORT` = 3, `WAIT_LONG` = 5, `WAIT_CLEAR` = 7.
- Reset values: hold `rst` for 3 cycles → all outputs at their reset values, `lcd_en` never high during reset. After release, `init_done` first high at cycle 64.
- Command stream: capture `lcd_data` on each `lcd_en` rise → exactly 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C, each with `lcd_en` high for exactly 2 cycles. `lcd_rs` = `lcd_rw` = 0 throughout.
- Settle gaps: measure the low time between consecutive `lcd_en` pulses → 6, 4, 4, 4, 8, 4, 4 cycles (1 + wait_k of the preceding command, k = 0..6). After the last pulse, 3 cycles of settle, then `init_done`.
- Reinit: pulse `reinit` at cycle 70 → `init_done` = 0 at 71, first `lcd_en` rise at 82, `init_done` high again at 135. A `reinit` pulse at cycle 30 (mid-sequence) changes nothing.
- Reset mid-operation: assert `rst` during the pulse of command 5 (0x01) → `lcd_en` = 0 and `lcd_data` = 0x00 on the next edge. After release the sequence restarts from command 0 and completes at cycle 64.
- Simultaneous events: `rst` and `reinit` high together in S_DONE → reset behaviour only, with `init_done` = 0 on the next edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and types shared by the LCD init sequencer, the strobe
// engine and the message-display FSM.
//   - HD44780 command byte constants
//   - sequencer / strobe state enums, settle-time class enum
//   - the fixed power-on command table (byte + settle class per index)
//   - cnt_width(): delay counter width for a given largest cycle count
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] LCD_DISP_OFF     = 8'h08;
    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_LINE2        = 8'hC0;

    localparam int N_INIT_CMDS = 8;

    // Sequencer level: power wait, command issue (delegated to lcd_strobe), done.
    typedef enum logic [1:0] {
        S_POWER_WAIT,
        S_RUN,
        S_DONE
    } seq_state_t;

    // Strobe engine phases for a single bus write.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT
    } strobe_state_t;

    typedef enum logic [1:0] {
        WAIT_CLS_SHORT,
        WAIT_CLS_LONG,
        WAIT_CLS_CLEAR
    } wait_class_t;

    function automatic logic [7:0] init_cmd_byte(input int idx);
        logic [7:0] b;
        case (idx)
            0, 1, 2, 3: b = LCD_FUNC_8BIT_2L;
            4:          b = LCD_DISP_OFF;
            5:          b = LCD_CLEAR;
            6:          b = LCD_ENTRY_INC;
            default:    b = LCD_DISP_ON;
        endcase
        return b;
    endfunction

    function automatic wait_class_t init_cmd_wait(input int idx);
        wait_class_t c;
        case (idx)
            0:       c = WAIT_CLS_LONG;
            5:       c = WAIT_CLS_CLEAR;
            default: c = WAIT_CLS_SHORT;
        endcase
        return c;
    endfunction

    // At least 18 bits, widened if any timing parameter needs more.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 18;
        for (int b = 18; b < 32; b++) begin
            if ((64'd1 << b) <= 64'(max_val)) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_strobe.sv
// lcd_strobe: generic single-write engine for the HD44780 bus.
// A start request latches byte / rs / settle time, then runs
// setup (1 cycle) -> enable high (EN_PULSE cycles) -> settle (i_wait cycles).
// A start arriving in the last settle cycle chains directly into the next
// setup, so back-to-back commands have no idle gap.
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : request a write (accepted when idle or on o_done)
//   i_data     : command/data byte
//   i_rs       : register select for this write
//   i_wait     : settle cycles after the enable pulse (must be >= 1)
//   o_busy     : write in progress
//   o_done     : one-cycle pulse in the last settle cycle
//   o_en       : enable strobe (registered)
//   o_rs       : latched register select
//   o_data     : latched byte, held until the next accepted start
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int EN_PULSE = 20,
    parameter int CNT_W    = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [7:0]       i_data,
    input  logic             i_rs,
    input  logic [CNT_W-1:0] i_wait,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_en,
    output logic             o_rs,
    output logic [7:0]       o_data
);

    strobe_state_t    r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_wait;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_en;
    logic             w_load;
    logic             w_wait_end;

    assign w_wait_end = (r_state == S_WAIT) && (r_cnt == (r_wait - 1'b1));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (i_start) begin
                    w_state_next = S_SETUP;
                    w_load       = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_next = S_PULSE;
                w_cnt_next   = '0;
            end
            S_PULSE: begin
                if (r_cnt == CNT_W'(EN_PULSE - 1)) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT: begin
                if (w_wait_end) begin
                    w_cnt_next = '0;
                    if (i_start) begin
                        w_state_next = S_SETUP;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Enable is registered from the next state so it is glitch-free.
            r_en    <= (w_state_next == S_PULSE);
            if (w_load) begin
                r_data <= i_data;
                r_rs   <= i_rs;
                r_wait <= i_wait;
            end
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = w_wait_end;
    assign o_en   = r_en;
    assign o_rs   = r_rs;
    assign o_data = r_data;

endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: HD44780 power-on initialisation sequencer.
// Waits POWERON_CYCLES, then issues the 8-entry 8-bit-mode command table
// through lcd_strobe, then raises init_done (sticky) to hand the bus to the
// display FSM. reinit in the done state reruns the whole sequence.
//   clk, rst  : 50 MHz clock, synchronous active-high reset
//   reinit    : single-cycle rerun request, honoured only when done
//   lcd_rs    : register select (always 0 here)
//   lcd_rw    : read/write (always 0, write)
//   lcd_en    : enable strobe
//   lcd_data  : command byte, stable while lcd_en is high
//   init_done : sequence complete
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int POWERON_CYCLES = 2_000_000,
    parameter int EN_PULSE       = 20,
    parameter int WAIT_SHORT     = 2500,
    parameter int WAIT_LONG      = 205_000,
    parameter int WAIT_CLEAR     = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       init_done
);

    localparam int MAX_A = (POWERON_CYCLES > WAIT_LONG) ? POWERON_CYCLES : WAIT_LONG;
    localparam int MAX_B = (WAIT_CLEAR > WAIT_SHORT) ? WAIT_CLEAR : WAIT_SHORT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > EN_PULSE) ? MAX_C : EN_PULSE;
    localparam int CNT_W = cnt_width(MAX_P);

    // Command table resolved to byte + settle cycles per index.
    logic [7:0]       w_cmd_byte [N_INIT_CMDS];
    logic [CNT_W-1:0] w_cmd_wait [N_INIT_CMDS];

    genvar gi;
    generate
        for (gi = 0; gi < N_INIT_CMDS; gi++) begin : g_cmd
            localparam wait_class_t CLS = init_cmd_wait(gi);
            assign w_cmd_byte[gi] = init_cmd_byte(gi);
            assign w_cmd_wait[gi] = (CLS == WAIT_CLS_LONG)  ? CNT_W'(WAIT_LONG)  :
                                    (CLS == WAIT_CLS_CLEAR) ? CNT_W'(WAIT_CLEAR) :
                                                              CNT_W'(WAIT_SHORT);
        end
    endgenerate

    seq_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_idx, w_idx_next;
    logic             r_done;

    logic             w_start;
    logic [2:0]       w_start_idx;
    logic             w_busy;
    logic             w_strobe_done;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_idx_next   = r_idx;
        w_start      = 1'b0;
        w_start_idx  = r_idx;
        case (r_state)
            S_POWER_WAIT: begin
                // The counter runs 0..POWERON_CYCLES, matching the first
                // setup cycle landing exactly POWERON_CYCLES after release.
                if ((r_cnt == CNT_W'(POWERON_CYCLES)) && !w_busy) begin
                    w_state_next = S_RUN;
                    w_start      = 1'b1;
                    w_start_idx  = 3'd0;
                    w_idx_next   = 3'd0;
                end else if (r_cnt != CNT_W'(POWERON_CYCLES)) begin
                    w_cnt_next = r_cnt + 1'b1;
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            S_RUN: begin
                if (w_strobe_done) begin
                    if (r_idx == 3'(N_INIT_CMDS - 1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        // Chain the next command into the strobe's last settle cycle.
                        w_start     = 1'b1;
                        w_start_idx = r_idx + 3'd1;
                        w_idx_next  = r_idx + 3'd1;
                    end
                end
            end
            S_DONE: begin
                if (reinit) begin
                    w_state_next = S_POWER_WAIT;
                    w_idx_next   = 3'd0;
                end
            end
            default: begin
                w_state_next = S_POWER_WAIT;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_POWER_WAIT;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_done  <= (w_state_next == S_DONE);
        end
    end

    lcd_strobe #(
        .EN_PULSE (EN_PULSE),
        .CNT_W    (CNT_W)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_cmd_byte[w_start_idx]),
        .i_rs    (1'b0),
        .i_wait  (w_cmd_wait[w_start_idx]),
        .o_busy  (w_busy),
        .o_done  (w_strobe_done),
        .o_en    (lcd_en),
        .o_rs    (lcd_rs),
        .o_data  (lcd_data)
    );

    assign lcd_rw    = 1'b0;
    assign init_done = r_done;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Self-checking bench for lcd_init_seq with small timing parameters.
module tb_lcd_init_seq;

    localparam int P_PWR   = 10;
    localparam int P_EN    = 2;
    localparam int P_SHORT = 3;
    localparam int P_LONG  = 5;
    localparam int P_CLEAR = 7;
    localparam int T_DONE  = 64;

    logic       clk;
    logic       rst;
    logic       reinit;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       init_done;

    lcd_init_seq #(
        .POWERON_CYCLES (P_PWR),
        .EN_PULSE       (P_EN),
        .WAIT_SHORT     (P_SHORT),
        .WAIT_LONG      (P_LONG),
        .WAIT_CLEAR     (P_CLEAR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reinit    (reinit),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected command stream: rise cycle, byte, low gap before this pulse.
    typedef struct {
        int         rise;
        logic [7:0] data;
        int         gap_before;
    } vec_t;
    vec_t vecs [8];

    int n_tests;
    int n_fail;
    int cyc;

    // Monitor records
    int rise_cyc  [16];
    int rise_data [16];
    int width     [16];
    int gap       [16];
    int n_rise;
    int last_fall;
    int first_done;
    int rsrw_bad;
    logic prev_en;
    logic prev_done;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 16; i++) begin
            rise_cyc[i]  = -1;
            rise_data[i] = -1;
            width[i]     = -1;
            gap[i]       = -1;
        end
        n_rise     = 0;
        last_fall  = -1;
        first_done = -1;
        rsrw_bad   = 0;
        prev_en    = lcd_en;
        prev_done  = init_done;
    endtask

    // One clock: sample #1 after the edge and update the monitor.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (lcd_rs || lcd_rw) rsrw_bad++;
        if (lcd_en && !prev_en) begin
            if (n_rise < 16) begin
                rise_cyc[n_rise]  = cyc;
                rise_data[n_rise] = int'(lcd_data);
                gap[n_rise]       = (last_fall >= 0) ? (cyc - last_fall) : -1;
            end
            n_rise++;
        end
        if (!lcd_en && prev_en) begin
            if (n_rise >= 1 && n_rise <= 16) width[n_rise-1] = cyc - rise_cyc[n_rise-1];
            last_fall = cyc;
        end
        if (init_done && !prev_done && first_done < 0) first_done = cyc;
        prev_en   = lcd_en;
        prev_done = init_done;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("rst%0d_en", i),   int'(lcd_en),    0);
            chk($sformatf("rst%0d_data", i), int'(lcd_data),  0);
            chk($sformatf("rst%0d_done", i), int'(init_done), 0);
            chk($sformatf("rst%0d_rsrw", i), int'(lcd_rs | lcd_rw), 0);
        end
        rst = 1'b0;
        cyc = -1;
        clear_mon();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_npulses"}, n_rise, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_rise%0d", tag, k),  rise_cyc[k],  vecs[k].rise);
            chk($sformatf("%s_data%0d", tag, k),  rise_data[k], int'(vecs[k].data));
            chk($sformatf("%s_width%0d", tag, k), width[k],     P_EN);
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), gap[k], vecs[k].gap_before);
        end
        chk({tag, "_done_cycle"}, first_done, T_DONE);
        chk({tag, "_last_settle"}, first_done - last_fall, P_SHORT);
        chk({tag, "_rsrw_high_cycles"}, rsrw_bad, 0);
    endtask

    initial begin
        vecs[0] = '{rise: 11, data: 8'h38, gap_before: -1};
        vecs[1] = '{rise: 19, data: 8'h38, gap_before: 6};
        vecs[2] = '{rise: 25, data: 8'h38, gap_before: 4};
        vecs[3] = '{rise: 31, data: 8'h38, gap_before: 4};
        vecs[4] = '{rise: 37, data: 8'h08, gap_before: 4};
        vecs[5] = '{rise: 43, data: 8'h01, gap_before: 4};
        vecs[6] = '{rise: 53, data: 8'h06, gap_before: 8};
        vecs[7] = '{rise: 59, data: 8'h0C, gap_before: 4};

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        reinit  = 1'b0;

        // Reset values, then a full run with an ignored mid-sequence reinit.
        do_reset(3);
        run_to(29);
        reinit = 1'b1;
        step();                      // reinit sampled at cycle 30
        reinit = 1'b0;
        run_to(69);
        check_stream("run1");
        chk("done_held", int'(init_done), 1);
        chk("done_data", int'(lcd_data), 8'h0C);

        // Reinit in the done state at cycle 70.
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        chk("reinit_done_low70", int'(init_done), 0);
        clear_mon();
        step();
        chk("reinit_done_low71", int'(init_done), 0);
        run_to(140);
        chk("reinit_first_rise", rise_cyc[0], 70 + 1 + 11);
        chk("reinit_npulses", n_rise, 8);
        chk("reinit_done_cycle", first_done, 70 + 1 + T_DONE);

        // Reset during the enable pulse of the clear command.
        do_reset(2);
        run_to(43);
        chk("mid_en_high", int'(lcd_en), 1);
        chk("mid_data_clear", int'(lcd_data), 8'h01);
        rst = 1'b1;
        step();
        chk("mid_rst_en", int'(lcd_en), 0);
        chk("mid_rst_data", int'(lcd_data), 0);
        chk("mid_rst_done", int'(init_done), 0);
        step();
        rst = 1'b0;
        cyc = -1;
        clear_mon();
        run_to(69);
        check_stream("run2");

        // rst and reinit together in the done state: reset wins.
        chk("sim_pre_done", int'(init_done), 1);
        rst    = 1'b1;
        reinit = 1'b1;
        step();
        chk("sim_done", int'(init_done), 0);
        chk("sim_en", int'(lcd_en), 0);
        chk("sim_data", int'(lcd_data), 0);
        rst    = 1'b0;
        reinit = 1'b0;
        cyc = -1;
        clear_mon();
        run_to(20);
        chk("sim_first_rise", rise_cyc[0], 11);
        chk("sim_first_data", rise_data[0], 8'h38);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
